// File: rtl/cabac_ctx_init_pkg.sv
// Shared constants and FSM encoding for the CABAC context-initialisation sequencer.
package cabac_ctx_init_pkg;

  localparam int CABAC_CTX_NUM = 64;
  localparam int CABAC_QP_MAX  = 51;
  localparam int CABAC_PRE_MIN = 1;
  localparam int CABAC_PRE_MAX = 126;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } ctx_state_e;

endpackage

// File: rtl/cabac_ctx_init_calc.sv
// Combinational HEVC context-state derivation from one init word {m, n} and the slice QP.
module cabac_ctx_init_calc
  import cabac_ctx_init_pkg::*;
#(
  parameter int WORD_WIDTH = 16,
  parameter int CTX_WIDTH  = 7
) (
  input  logic [WORD_WIDTH-1:0] rom_word,
  input  logic [5:0]            qp,
  output logic [CTX_WIDTH-1:0]  ctx_word
);

  // Clamp the pre-state into the legal probability range before the MPS split.
  function automatic logic [6:0] sat_pre(input logic signed [14:0] v);
    if (v < 15'(CABAC_PRE_MIN))
      return 7'(CABAC_PRE_MIN);
    else if (v > 15'(CABAC_PRE_MAX))
      return 7'(CABAC_PRE_MAX);
    else
      return v[6:0];
  endfunction

  logic signed [7:0]  slope_m;
  logic signed [7:0]  offset_n;
  logic signed [13:0] prod;
  logic signed [13:0] sh;
  logic signed [14:0] sum;
  logic [6:0]         pre;
  logic               val_mps;
  logic [5:0]         p_state;

  assign slope_m  = $signed(rom_word[15:8]);
  assign offset_n = $signed(rom_word[7:0]);

  // QP is unsigned; zero-extend so the product keeps the sign of the slope.
  assign prod = $signed({{6{slope_m[7]}}, slope_m}) * $signed({8'b0, qp});
  assign sh   = prod >>> 4;
  assign sum  = $signed({sh[13], sh}) + $signed({{7{offset_n[7]}}, offset_n});
  assign pre  = sat_pre(sum);

  assign val_mps  = pre[6];
  assign p_state  = val_mps ? pre[5:0] : (6'd63 - pre[5:0]);
  assign ctx_word = {p_state, val_mps};

endmodule

// File: rtl/cabac_ctx_init.sv
// Slice-start sequencer: streams the 64 context-init ROM words through the state
// calculator and writes one {pStateIdx, valMps} per cycle into context memory.
module cabac_ctx_init
  import cabac_ctx_init_pkg::*;
#(
  parameter int CTX_NUM    = 64,
  parameter int ADDR_WIDTH = 6,
  parameter int WORD_WIDTH = 16,
  parameter int CTX_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic [5:0]            slice_qp_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  rom_r_en_o,
  output logic [ADDR_WIDTH-1:0] rom_r_addr_o,
  input  logic [WORD_WIDTH-1:0] rom_r_data_i,
  output logic                  ctx_w_en_o,
  output logic [ADDR_WIDTH-1:0] ctx_w_addr_o,
  output logic [CTX_WIDTH-1:0]  ctx_w_data_o
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(CTX_NUM - 1);

  ctx_state_e            state_q;
  ctx_state_e            state_d;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic [5:0]            qp_r;
  logic                  last_rd;
  logic                  last_wr;

  logic                  vld_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic                  vld_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;
  logic [CTX_WIDTH-1:0]  data_p1;
  logic [CTX_WIDTH-1:0]  calc_word;

  assign last_rd = (rd_cnt == LAST_ADDR);
  assign last_wr = vld_p1 && (addr_p1 == LAST_ADDR);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_i) state_d = ST_READ;
      ST_READ:  if (last_rd) state_d = ST_DRAIN;
      ST_DRAIN: if (last_wr) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      rd_cnt  <= '0;
    end else begin
      state_q <= state_d;
      rd_cnt  <= (state_q == ST_READ) ? rd_cnt + 1'b1 : '0;
    end
  end

  // QP is captured once per slice so later input changes cannot disturb a run.
  always_ff @(posedge clk) begin
    if (state_q == ST_IDLE && start_i)
      qp_r <= (slice_qp_i > 6'(CABAC_QP_MAX)) ? 6'(CABAC_QP_MAX) : slice_qp_i;
  end

  // Stage p0: ROM word for addr_p0 is presented this cycle.
  always_ff @(posedge clk) begin
    if (rst)
      vld_p0 <= 1'b0;
    else
      vld_p0 <= (state_q == ST_READ);
  end

  always_ff @(posedge clk) begin
    addr_p0 <= rd_cnt;
  end

  cabac_ctx_init_calc #(
    .WORD_WIDTH (WORD_WIDTH),
    .CTX_WIDTH  (CTX_WIDTH)
  ) u_calc (
    .rom_word (rom_r_data_i),
    .qp       (qp_r),
    .ctx_word (calc_word)
  );

  // Stage p1: registered context-memory write.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      addr_p1 <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= vld_p0;
      if (vld_p0) begin
        addr_p1 <= addr_p0;
        data_p1 <= calc_word;
      end
    end
  end

  assign rom_r_en_o   = (state_q == ST_READ);
  assign rom_r_addr_o = rd_cnt;
  assign busy_o       = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done_o       = (state_q == ST_DONE);
  assign ctx_w_en_o   = vld_p1;
  assign ctx_w_addr_o = addr_p1;
  assign ctx_w_data_o = data_p1;

endmodule

// File: tb/tb_cabac_ctx_init.sv
// Directed bench for cabac_ctx_init with a registered 64-word ROM model.
module tb_cabac_ctx_init;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic [5:0]  slice_qp_i;
  logic        busy_o;
  logic        done_o;
  logic        rom_r_en_o;
  logic [5:0]  rom_r_addr_o;
  logic [15:0] rom_r_data_i;
  logic        ctx_w_en_o;
  logic [5:0]  ctx_w_addr_o;
  logic [6:0]  ctx_w_data_o;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] rom [64];

  always #5 clk = ~clk;

  cabac_ctx_init dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .slice_qp_i   (slice_qp_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .rom_r_en_o   (rom_r_en_o),
    .rom_r_addr_o (rom_r_addr_o),
    .rom_r_data_i (rom_r_data_i),
    .ctx_w_en_o   (ctx_w_en_o),
    .ctx_w_addr_o (ctx_w_addr_o),
    .ctx_w_data_o (ctx_w_data_o)
  );

  // Registered ROM; output is garbage whenever the read enable is low.
  always @(posedge clk) begin
    if (rom_r_en_o)
      rom_r_data_i <= rom[rom_r_addr_o];
    else
      rom_r_data_i <= 16'($urandom);
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Hand-computed context words; tbl 0: qp 26, tbl 1: qp 0, tbl 2: qp 51.
  function automatic logic [6:0] exp_data(input int tbl, input int a);
    case (a)
      0:  return (tbl == 0) ? 7'h10 : (tbl == 1) ? 7'h01 : 7'h1E;
      1:  return (tbl == 0) ? 7'h10 : (tbl == 1) ? 7'h51 : 7'h6E;
      2:  return (tbl == 0) ? 7'h30 : (tbl == 1) ? 7'h31 : 7'h7C;
      3:  return (tbl == 0) ? 7'h00 : (tbl == 1) ? 7'h41 : 7'h3E;
      4:  return (tbl == 0) ? 7'h21 : (tbl == 1) ? 7'h0E : 7'h4F;
      63: return 7'h7D;
      default: return 7'h01;
    endcase
  endfunction

  // Starts a run (start sampled at E0) and checks cycles 1..67 against the fixed timeline.
  task automatic run(input logic [5:0] qp, input int tbl, input int pulse_cyc,
                     input int qp_change_cyc, input int rst_cyc);
    int dones;
    int writes;
    dones  = 0;
    writes = 0;
    slice_qp_i = qp;
    start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    for (int k = 1; k <= 67; k++) begin
      if (rst_cyc != 0 && k > rst_cyc) begin
        chk("abort_rom_en", 16'(rom_r_en_o), 16'd0);
        chk("abort_w_en",   16'(ctx_w_en_o), 16'd0);
        chk("abort_busy",   16'(busy_o),     16'd0);
        chk("abort_done",   16'(done_o),     16'd0);
      end else begin
        chk("rom_en", 16'(rom_r_en_o), 16'(k <= 64));
        if (k <= 64) chk("rom_addr", 16'(rom_r_addr_o), 16'(k - 1));
        chk("w_en", 16'(ctx_w_en_o), 16'(k >= 3 && k <= 66));
        if (k >= 3 && k <= 66) begin
          chk("w_addr", 16'(ctx_w_addr_o), 16'(k - 3));
          chk("w_data", 16'(ctx_w_data_o), 16'(exp_data(tbl, k - 3)));
        end
        chk("busy", 16'(busy_o), 16'(k <= 66));
        chk("done", 16'(done_o), 16'(k == 67));
      end
      if (ctx_w_en_o) writes++;
      if (done_o) dones++;
      start_i = (k == pulse_cyc);
      if (k == qp_change_cyc) slice_qp_i = 6'd0;
      if (rst_cyc != 0) rst = (k == rst_cyc);
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    rst = 1'b0;
    if (rst_cyc == 0) begin
      chk("write_count", 16'(writes), 16'd64);
      chk("done_count",  16'(dones),  16'd1);
    end else begin
      chk("abort_done_count", 16'(dones), 16'd0);
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 16'h0040;
    rom[0]  = 16'hfb40;
    rom[1]  = 16'he268;
    rom[2]  = 16'he258;
    rom[3]  = 16'hec60;
    rom[4]  = 16'h0f38;
    rom[63] = 16'h7f7f;

    rst = 1'b1;
    start_i = 1'b0;
    slice_qp_i = 6'd0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_busy",   16'(busy_o),       16'd0);
    chk("rst_done",   16'(done_o),       16'd0);
    chk("rst_rom_en", 16'(rom_r_en_o),   16'd0);
    chk("rst_w_en",   16'(ctx_w_en_o),   16'd0);
    chk("rst_raddr",  16'(rom_r_addr_o), 16'd0);
    chk("rst_waddr",  16'(ctx_w_addr_o), 16'd0);
    chk("rst_wdata",  16'(ctx_w_data_o), 16'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(6'd26, 0, 0, 0, 0);
    // Back-to-back: this start lands in cycle 68 of the previous run; stray pulse in cycle 30.
    run(6'd0, 1, 30, 0, 0);
    // QP above 51 saturates; the mid-run QP change must not matter.
    run(6'd63, 2, 0, 10, 0);
    run(6'd51, 2, 0, 0, 40);
    run(6'd26, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
